// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the MAC accumulate stage.
// Pure declarations: no latency or flow control of its own.
package mac_pkg;
    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;
endpackage

// File: rtl/mac_accumulator_acc_add.sv
// Zero-extending adder of product onto accumulator with carry-out.
// Combinational (0 cycles); no flow control.
module acc_add #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign sum      = full_sum[ACC_W-1:0];
    assign carry    = full_sum[ACC_W];
endmodule

// File: rtl/mac_accumulator.sv
// Sums products until a last-marked one, then presents the registered result one cycle later.
// Prod_Ready drops only while a result waits on Res_Ready or during Soft_Clr.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Soft_Clr,
    input  logic              Prod_Valid,
    output logic              Prod_Ready,
    input  logic [PROD_W-1:0] Product,
    input  logic              Prod_Last,
    output logic              Res_Valid,
    input  logic              Res_Ready,
    output logic [ACC_W-1:0]  Result,
    output logic [CNT_W-1:0]  Res_Count,
    output logic              Overflow
);
    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_vld_q, res_vld_d;

    logic [ACC_W-1:0]   sum;
    logic               carry;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;

    // acc_q is already zero in DONE, so one adder serves both the first
    // term after a result and ordinary accumulation.
    acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_acc_add (
        .acc   (acc_q),
        .prod  (Product),
        .sum   (sum),
        .carry (carry)
    );

    assign Prod_Ready = !Soft_Clr && ((state_q == ACC) || Res_Ready);
    assign accept     = Prod_Valid && Prod_Ready;
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
        res_vld_d = res_vld_q;

        if (Soft_Clr) begin
            state_d   = ACC;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            res_d     = '0;
            res_cnt_d = '0;
            res_ovf_d = 1'b0;
            res_vld_d = 1'b0;
        end else begin
            if ((state_q == DONE) && Res_Ready) begin
                res_vld_d = 1'b0;
                state_d   = ACC;
            end
            if (accept) begin
                if (Prod_Last) begin
                    res_d     = sum;
                    res_cnt_d = cnt_inc;
                    res_ovf_d = ovf_q | carry;
                    res_vld_d = 1'b1;
                    state_d   = DONE;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
            res_vld_q <= res_vld_d;
        end
    end

    assign Res_Valid = res_vld_q;
    assign Result    = res_q;
    assign Res_Count = res_cnt_q;
    assign Overflow  = res_ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed vectors for mac_accumulator; a 17-bit-accumulator copy shares the stimulus.
module tb_mac_accumulator;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Soft_Clr;
    logic        Prod_Valid;
    logic [15:0] Product;
    logic        Prod_Last;
    logic        Res_Ready;

    logic        prod_rdy, res_vld, ovf;
    logic [31:0] result;
    logic [7:0]  res_cnt;

    logic        prod_rdy17, res_vld17, ovf17;
    logic [16:0] result17;
    logic [7:0]  res_cnt17;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    mac_accumulator dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Soft_Clr   (Soft_Clr),
        .Prod_Valid (Prod_Valid),
        .Prod_Ready (prod_rdy),
        .Product    (Product),
        .Prod_Last  (Prod_Last),
        .Res_Valid  (res_vld),
        .Res_Ready  (Res_Ready),
        .Result     (result),
        .Res_Count  (res_cnt),
        .Overflow   (ovf)
    );

    mac_accumulator #(.ACC_W(17)) dut17 (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Soft_Clr   (Soft_Clr),
        .Prod_Valid (Prod_Valid),
        .Prod_Ready (prod_rdy17),
        .Product    (Product),
        .Prod_Last  (Prod_Last),
        .Res_Valid  (res_vld17),
        .Res_Ready  (Res_Ready),
        .Result     (result17),
        .Res_Count  (res_cnt17),
        .Overflow   (ovf17)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Presents one product for exactly one edge; caller ensures Prod_Ready is high.
    task automatic send(input logic [15:0] p, input logic last);
        Prod_Valid = 1'b1;
        Product    = p;
        Prod_Last  = last;
        tick();
        Prod_Valid = 1'b0;
        Prod_Last  = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; Soft_Clr = 1'b0; Prod_Valid = 1'b0;
        Product = '0; Prod_Last = 1'b0; Res_Ready = 1'b1;
        repeat (3) tick();
        chk("rst_vld", {31'b0, res_vld}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cnt", {24'b0, res_cnt}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        Rst_n = 1'b1;
        #1;
        chk("rst_prod_rdy", {31'b0, prod_rdy}, 32'd1);
        tick();

        // 9 + 12 + 225 + 0 = 246
        send(16'd9, 1'b0);
        send(16'd12, 1'b0);
        send(16'd225, 1'b0);
        send(16'd0, 1'b1);
        chk("vec_vld", {31'b0, res_vld}, 32'd1);
        chk("vec_result", result, 32'd246);
        chk("vec_cnt", {24'b0, res_cnt}, 32'd4);
        chk("vec_ovf", {31'b0, ovf}, 32'd0);
        tick();
        chk("vec_vld_drop", {31'b0, res_vld}, 32'd0);

        // Backpressure with a last product waiting.
        Res_Ready = 1'b0;
        send(16'd100, 1'b1);
        Prod_Valid = 1'b1; Product = 16'd5; Prod_Last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_prod_rdy", {31'b0, prod_rdy}, 32'd0);
            chk("bp_result", result, 32'd100);
            chk("bp_vld", {31'b0, res_vld}, 32'd1);
            tick();
        end
        Res_Ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'b0, prod_rdy}, 32'd1);
        tick();
        Prod_Valid = 1'b0; Prod_Last = 1'b0;
        chk("bp_next_vld", {31'b0, res_vld}, 32'd1);
        chk("bp_next_result", result, 32'd5);
        chk("bp_next_cnt", {24'b0, res_cnt}, 32'd1);
        tick();
        chk("bp_vld_drop", {31'b0, res_vld}, 32'd0);

        // Back-to-back single-term results.
        send(16'hFFFF, 1'b1);
        chk("b2b_a_result", result, 32'd65535);
        chk("b2b_a_cnt", {24'b0, res_cnt}, 32'd1);
        chk("b2b_a_vld", {31'b0, res_vld}, 32'd1);
        send(16'h0001, 1'b1);
        chk("b2b_b_result", result, 32'd1);
        chk("b2b_b_cnt", {24'b0, res_cnt}, 32'd1);
        chk("b2b_b_vld", {31'b0, res_vld}, 32'd1);

        // 3 x 0xFFFF = 0x2FFFD; the 17-bit copy wraps to 0x0FFFD.
        send(16'hFFFF, 1'b0);
        send(16'hFFFF, 1'b0);
        send(16'hFFFF, 1'b1);
        chk("ovf17_result", {15'b0, result17}, 32'h0FFFD);
        chk("ovf17_flag", {31'b0, ovf17}, 32'd1);
        chk("ovf17_cnt", {24'b0, res_cnt17}, 32'd3);
        chk("ovf32_result", result, 32'h2FFFD);
        chk("ovf32_flag", {31'b0, ovf}, 32'd0);
        send(16'd2, 1'b1);
        chk("ovf17_next_flag", {31'b0, ovf17}, 32'd0);
        chk("ovf17_next_result", {15'b0, result17}, 32'd2);

        // Soft clear mid-stream drops the offered product and the partial sum.
        send(16'd50, 1'b0);
        send(16'd60, 1'b0);
        Soft_Clr = 1'b1; Prod_Valid = 1'b1; Product = 16'd99; Prod_Last = 1'b1;
        #1;
        chk("clr_prod_rdy", {31'b0, prod_rdy}, 32'd0);
        tick();
        Soft_Clr = 1'b0; Prod_Valid = 1'b0; Prod_Last = 1'b0;
        chk("clr_vld", {31'b0, res_vld}, 32'd0);
        chk("clr_result", result, 32'd0);
        send(16'd7, 1'b1);
        chk("clr_after_result", result, 32'd7);
        chk("clr_after_cnt", {24'b0, res_cnt}, 32'd1);

        // Asynchronous reset between edges while a partial sum is held.
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        send(16'd5, 1'b0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_result", result, 32'd0);
        chk("arst_cnt", {24'b0, res_cnt}, 32'd0);
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
        send(16'd4, 1'b0);
        send(16'd5, 1'b1);
        chk("arst_after_result", result, 32'd9);
        chk("arst_after_cnt", {24'b0, res_cnt}, 32'd2);
        chk("arst_after_vld", {31'b0, res_vld}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
Accumulate stage directly downstream of the Vedic multiplier tree in the MAC unit. Consumes one unsigned product per handshake and sums products into a wide accumulator until a last-marked product arrives. Presents the completed dot-product result on a valid/ready output port to the NPU writeback path.

Parameters:
PROD_W, 16, product width; matches the 8x8 Vedic multiplier output.
ACC_W, 32, accumulator and result width; must be greater than PROD_W.
CNT_W, 8, width of the accumulated-term counter.

Ports:
Clk  input  1  single clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
Soft_Clr  input  1  synchronous abort; clears all accumulation state.
Prod_Valid  input  1  Product is valid.
Prod_Ready  output  1  stage accepts a product this cycle.
Product  input  PROD_W  unsigned product from the multiplier.
Prod_Last  input  1  final term of the current dot product; qualified by Prod_Valid.
Res_Valid  output  1  Result, Res_Count and Overflow are valid.
Res_Ready  input  1  downstream accepts the result.
Result  output  ACC_W  accumulated sum.
Res_Count  output  CNT_W  number of products in Result.
Overflow  output  1  a carry out of ACC_W occurred in this result.

Behaviour:
- Clock and reset: one clock, Clk. Rst_n is asynchronous and active-low.
- Reset: asserting Rst_n low clears all state immediately.
  - State = ACC; acc = 0; cnt = 0; ovf = 0.
  - Result = 0; Res_Count = 0; Overflow = 0; Res_Valid = 0.
  - Prod_Ready = 1 once Rst_n is released.
- Product handshake: a product is accepted when Prod_Valid & Prod_Ready.
- States: ACC and DONE.
- ACC state:
  - Prod_Ready = 1.
  - On accept without Prod_Last: acc <= acc + zero-extended Product, with the sum wrapping modulo 2^ACC_W.
  - On accept without Prod_Last: ovf <= ovf | carry-out.
  - On accept without Prod_Last: cnt <= cnt + 1, saturating at 2^CNT_W - 1.
- Accept with Prod_Last (from either state):
  - Result <= acc + Product (final sum); Res_Count <= cnt + 1 (saturating); Overflow <= ovf | carry-out.
  - Res_Valid <= 1; state <= DONE.
  - acc, cnt and ovf clear to 0.
  - Latency: last product accepted on cycle N; Res_Valid is high on cycle N+1.
- DONE state:
  - Res_Valid = 1. Result, Res_Count and Overflow hold stable until Res_Ready.
  - Prod_Ready = Res_Ready, which gives back-to-back operation with no bubble.
  - Res_Ready=1 with no product accepted: Res_Valid <= 0; state <= ACC.
  - Res_Ready=1 with a non-last product accepted: the product accumulates into the cleared acc; Res_Valid <= 0; state <= ACC.
  - Res_Ready=1 with a last product accepted: the new single-term result loads; Res_Valid stays 1; state stays DONE.
  - Res_Ready=0: Prod_Ready = 0; no state change.
- Soft_Clr: synchronous and highest priority.
  - Forces Prod_Ready = 0 combinationally, so no product is accepted that cycle.
  - Next cycle: state = ACC; acc, cnt, ovf and Res_Valid = 0.
  - Result, Res_Count and Overflow are also zeroed.
  - A pending unconsumed result is discarded.
- Prod_Last with Prod_Valid=0: ignored.
- Outputs are registered. Prod_Ready is the only combinational output, decoded from state, Res_Ready and Soft_Clr.

Decomposition:
- Shared package mac_pkg holds:
  - Default constants PROD_W=16, ACC_W=32, CNT_W=8.
  - State encoding ACC=1'b0, DONE=1'b1.
- One natural sub-module: acc_add.
  - Combinational zero-extend adder.
  - Inputs: acc and Product.
  - Outputs: sum[ACC_W-1:0] and carry-out.
  - Used by both the accumulate path and the final-sum path.

Test Plan:
- Vector test: products 9, 12, 225, 0 (last on 0), Res_Ready=1 → cycle after last, Res_Valid=1, Result=246, Res_Count=4, Overflow=0. Next cycle Res_Valid=0.
- Backpressure: finish a result of 100, hold Res_Ready=0 for 5 cycles with Prod_Valid=1 → Prod_Ready=0 throughout; Result stays 100. Raising Res_Ready accepts the pending product that same cycle.
- Single-term and back-to-back: Product=0xFFFF with last, then 0x0001 with last while Res_Ready=1 → Result=65535, Count=1, followed directly by Result=1, Count=1, with no idle cycle.
- Overflow (ACC_W=17): products 0xFFFF ×3, last on third.
  - Result = 0x2FFFD mod 2^17 = 0x0FFFD; Overflow=1; Count=3.
  - A following single-term result has Overflow=0.
- Soft_Clr mid-stream: accept 50 and 60, pulse Soft_Clr with Prod_Valid=1 (product dropped), then 7 with last → Result=7, Count=1.
- Async reset mid-stream: accumulate 3 products, drop Rst_n between clock edges → outputs clear before the next edge. After release, a 2-term vector of 4 and 5 gives Result=9.
